// File: rtl/chunk_pixel_serializer.sv
// Serializes 16-bit pixel chunks from a small FIFO into a 1-bit pixel stream, one pixel per pixel_en.
// Optional SERIALIZER_UNDERRUN_CNT_EN adds an 8-bit saturating count of underrun pixels.
module chunk_pixel_serializer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int LINE_PIXELS = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] chunk_in,
  input  logic        chunk_valid,
  output logic        chunk_ready,
  input  logic        line_start,
  input  logic        pixel_en,
  output logic        pixel_on,
  output logic        line_done,
  output logic        underrun
`ifdef SERIALIZER_UNDERRUN_CNT_EN
  ,
  output logic [7:0]  underrun_count
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int NW = $clog2(LINE_PIXELS + 1);

  typedef enum logic [1:0] {IDLE, FILL, ACTIVE, DONE} state_t;

  state_t          state_reg;
  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   fifo_count_reg;
  logic [NW-1:0]   pix_cnt_reg;
  logic [3:0]      bit_idx_reg;
  logic [15:0]     shift_reg;

  logic        push;
  logic        pop;
  logic        fifo_empty;
  logic        last_pixel;
  logic [15:0] fifo_head;

  assign chunk_ready = (fifo_count_reg < CW'(FIFO_DEPTH));
  assign push        = chunk_valid && chunk_ready;
  assign fifo_empty  = (fifo_count_reg == '0);
  assign fifo_head   = fifo_mem[rd_ptr_reg];
  assign last_pixel  = (pix_cnt_reg == NW'(LINE_PIXELS - 1));

  // Pop decision; line_start and rst both suppress any pop so the FIFO is left intact.
  always_comb begin
    pop = 1'b0;
    if (!rst && !line_start) begin
      case (state_reg)
        FILL:    pop = !fifo_empty && !(pixel_en && last_pixel);
        ACTIVE:  pop = pixel_en && (bit_idx_reg == 4'd15) && !last_pixel && !fifo_empty;
        default: pop = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_mem[wr_ptr_reg] <= chunk_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      pix_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
      pixel_on       <= 1'b0;
      line_done      <= 1'b0;
      underrun       <= 1'b0;
`ifdef SERIALIZER_UNDERRUN_CNT_EN
      underrun_count <= '0;
`endif
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + CW'(1);
        2'b01:   fifo_count_reg <= fifo_count_reg - CW'(1);
        default: fifo_count_reg <= fifo_count_reg;
      endcase

      line_done <= 1'b0;

      if (line_start) begin
        state_reg   <= FILL;
        pix_cnt_reg <= '0;
        bit_idx_reg <= '0;
        shift_reg   <= '0;
        pixel_on    <= 1'b0;
      end else begin
        case (state_reg)
          IDLE, DONE: pixel_on <= 1'b0;

          FILL: begin
            if (pixel_en) begin
              pix_cnt_reg <= pix_cnt_reg + NW'(1);
              if (fifo_empty) begin
                pixel_on <= 1'b0;
                underrun <= 1'b1;
`ifdef SERIALIZER_UNDERRUN_CNT_EN
                if (underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
`endif
              end else begin
                // Word arriving while pixels are already being strobed: serve bit 0 straight from the FIFO head.
                pixel_on    <= fifo_head[0];
                shift_reg   <= fifo_head;
                bit_idx_reg <= 4'd1;
                state_reg   <= ACTIVE;
              end
              if (last_pixel) begin
                line_done <= 1'b1;
                state_reg <= DONE;
              end
            end else if (!fifo_empty) begin
              shift_reg   <= fifo_head;
              bit_idx_reg <= 4'd0;
              state_reg   <= ACTIVE;
            end
          end

          ACTIVE: begin
            if (pixel_en) begin
              pixel_on    <= shift_reg[bit_idx_reg];
              pix_cnt_reg <= pix_cnt_reg + NW'(1);
              if (last_pixel) begin
                line_done <= 1'b1;
                state_reg <= DONE;
              end else if (bit_idx_reg == 4'd15) begin
                if (!fifo_empty) begin
                  shift_reg   <= fifo_head;
                  bit_idx_reg <= 4'd0;
                end else begin
                  state_reg <= FILL;
                end
              end else begin
                bit_idx_reg <= bit_idx_reg + 4'd1;
              end
            end
          end

          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chunk_pixel_serializer.sv
// Directed self-checking bench for chunk_pixel_serializer (default FIFO_DEPTH=4, LINE_PIXELS=480).
module tb_chunk_pixel_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] chunk_in = '0;
  logic        chunk_valid = 1'b0;
  logic        chunk_ready;
  logic        line_start = 1'b0;
  logic        pixel_en = 1'b0;
  logic        pixel_on;
  logic        line_done;
  logic        underrun;
`ifdef SERIALIZER_UNDERRUN_CNT_EN
  logic [7:0]  underrun_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  chunk_pixel_serializer #(.FIFO_DEPTH(4), .LINE_PIXELS(480)) dut (
    .clk(clk),
    .rst(rst),
    .chunk_in(chunk_in),
    .chunk_valid(chunk_valid),
    .chunk_ready(chunk_ready),
    .line_start(line_start),
    .pixel_en(pixel_en),
    .pixel_on(pixel_on),
    .line_done(line_done),
    .underrun(underrun)
`ifdef SERIALIZER_UNDERRUN_CNT_EN
    ,
    .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ls, input logic pe);
    line_start = ls;
    pixel_en   = pe;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    pixel_en   = 1'b0;
  endtask

  task automatic push(input logic [15:0] w);
    chunk_valid = 1'b1;
    chunk_in    = w;
    @(posedge clk);
    #1;
    chunk_valid = 1'b0;
  endtask

  // Offers n copies of w, advancing only on accepted handshakes, bounded by a cycle budget.
  task automatic produce(input logic [15:0] w, input int n);
    int sent = 0;
    int tries = 0;
    logic rdy;
    while (sent < n) begin
      chunk_valid = 1'b1;
      chunk_in    = w;
      rdy = chunk_ready;
      @(posedge clk);
      #1;
      if (rdy) sent++;
      tries++;
      if (tries > 3000) begin
        vectors++;
        miscompares++;
        $display("FAIL producer_timeout: observed %0d words sent, required %0d", sent, n);
        break;
      end
    end
    chunk_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] words [5];
    logic [15:0] wd;
    words[0] = 16'h00F1;
    words[1] = 16'h1234;
    words[2] = 16'hA5C3;
    words[3] = 16'h8001;
    words[4] = 16'h7E0F;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_ready", chunk_ready, 1);
    check("rst_pixel_on", pixel_on, 0);
    check("rst_line_done", line_done, 0);
    check("rst_underrun", underrun, 0);
`ifdef SERIALIZER_UNDERRUN_CNT_EN
    check("rst_ucount", underrun_count, 0);
`endif
    rst = 1'b0;
    $display("step: reset released");

    // Two words, first pixel and 32nd pixel set
    push(16'h0001);
    push(16'h8000);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b1);
      check($sformatf("two_word_px%0d", i), pixel_on, (i == 0 || i == 31) ? 1 : 0);
    end
    check("two_word_underrun", underrun, 0);
    $display("step: 32 pixels from 0x0001/0x8000");

    // FIFO full back-pressure: five words offered into a depth-4 FIFO
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chunk_valid = 1'b1;
      chunk_in    = words[k];
      @(posedge clk); #1;
      check($sformatf("fill_ready%0d", k), chunk_ready, (k < 3) ? 1 : 0);
    end
    chunk_in = words[4];
    step(1'b0, 1'b0);
    check("full_hold_ready", chunk_ready, 0);
    step(1'b1, 1'b0);
    check("full_ls_ready", chunk_ready, 0);
    step(1'b0, 1'b0);
    check("after_pop_ready", chunk_ready, 1);
    step(1'b0, 1'b0);
    check("fifth_stored_ready", chunk_ready, 0);
    chunk_valid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step(1'b0, 1'b1);
      wd = words[i / 16];
      check($sformatf("order_px%0d", i), pixel_on, wd[i % 16]);
    end
    $display("step: 5 words through depth-4 FIFO, 80 pixels");

    // Underrun on empty FIFO, then resume from a late word 0x000D
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("underrun_pixel", pixel_on, 0);
    check("underrun_flag", underrun, 1);
`ifdef SERIALIZER_UNDERRUN_CNT_EN
    check("underrun_count1", underrun_count, 1);
`endif
    push(16'h000D);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("resume_px0", pixel_on, 1);
    step(1'b0, 1'b1);
    check("resume_px1", pixel_on, 0);
    step(1'b0, 1'b1);
    check("resume_px2", pixel_on, 1);
    check("underrun_sticky", underrun, 1);
    $display("step: underrun and resume");

    // line_start wins over pixel_en; queued word survives; then a full 480-pixel line
    push(16'hFFFF);
    step(1'b1, 1'b1);
    check("ls_wins_pixel", pixel_on, 0);
    check("ls_wins_done", line_done, 0);
    fork
      produce(16'hFFFF, 29);
      begin
        step(1'b0, 1'b0);
        for (int i = 0; i < 480; i++) begin
          step(1'b0, 1'b1);
          check($sformatf("line_px%0d", i), pixel_on, 1);
          check($sformatf("line_done_px%0d", i), line_done, (i == 479) ? 1 : 0);
        end
        for (int i = 0; i < 2; i++) begin
          step(1'b0, 1'b1);
          check($sformatf("done_px%0d", i), pixel_on, 0);
          check($sformatf("done_ld%0d", i), line_done, 0);
        end
      end
    join
`ifdef SERIALIZER_UNDERRUN_CNT_EN
    check("full_line_ucount", underrun_count, 1);
`endif
    $display("step: full 480-pixel line of ones");

    // Reset mid-line at pixel 200 with 3 words queued
    step(1'b1, 1'b0);
    fork
      produce(16'hAAAA, 16);
      begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
          step(1'b0, 1'b1);
          check($sformatf("pre_rst_px%0d", i), pixel_on, i % 2);
        end
      end
    join
    check("queued_not_full", chunk_ready, 1);
    rst = 1'b1;
    chunk_valid = 1'b1;
    chunk_in = 16'hFFFF;
    @(posedge clk); #1;
    rst = 1'b0;
    chunk_valid = 1'b0;
    check("mid_rst_ready", chunk_ready, 1);
    check("mid_rst_pixel", pixel_on, 0);
    check("mid_rst_underrun", underrun, 0);
    check("mid_rst_done", line_done, 0);
`ifdef SERIALIZER_UNDERRUN_CNT_EN
    check("mid_rst_ucount", underrun_count, 0);
`endif
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("post_rst_empty_px", pixel_on, 0);
    check("post_rst_underrun", underrun, 1);
    $display("step: reset mid-line discards FIFO");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
